zap_memory_stage: RTL and testbench
===================================

# zap_memory_stage

Pipeline stage between the ALU and `zap_writeback`. It registers the ALU-stage result, destination indices, flags and exception indicators, and aligns and sign/zero-extends load data returned by the data cache. It presents everything to writeback one cycle later. It honours data-cache stalls by freezing and writeback flushes by invalidating.

## Interface
- `FLAG_WDT`, default 32, CPSR width.
- `PHY_REGS`, default 46, physical register count; index width is `$clog2(PHY_REGS)` (IW).

Ports (`name direction width meaning`):
- `i_clk in 1` – core clock.
- `i_reset in 1` – synchronous, active-high reset.
- `i_clear_from_writeback in 1` – flush; invalidates the stage.
- `i_data_stall in 1` – data cache not ready; freeze all state.
- `i_valid_alu in 1` – ALU output valid.
- `i_alu_result in 32` – ALU result, or effective address for memory ops.
- `i_flags_alu in FLAG_WDT` – flags from the ALU.
- `i_destination_index_alu in IW` – primary write index.
- `i_mem_srcdest_index_alu in IW` – load destination index.
- `i_mem_load_alu in 1` – instruction is a load.
- `i_mem_op_alu in 1` – instruction accesses memory (load or store).
- `i_sbyte_alu`, `i_ubyte_alu`, `i_shalf_alu`, `i_uhalf_alu in 1` each – access size/sign.
- `i_pc_plus_8_alu in 32` – buffered PC+8.
- `i_irq_alu`, `i_fiq_alu`, `i_instr_abt_alu`, `i_swi_alu`, `i_und_alu in 1` each – exception indicators.
- `i_mem_rd_data in 32` – raw word from the data cache, valid when `i_data_stall`=0.
- `i_mem_fault in 1` – data abort from the cache/MMU for the current access.
- `o_valid out 1`, `o_alu_result_ff out 32`, `o_flags_ff out FLAG_WDT`.
- `o_destination_index_ff out IW`, `o_mem_srcdest_index_ff out IW`, `o_mem_load_ff out 1`.
- `o_mem_rd_data out 32` – aligned and extended load data (registered).
- `o_pc_plus_8_ff out 32`.
- `o_irq_ff`, `o_fiq_ff`, `o_instr_abt_ff`, `o_swi_ff`, `o_und_ff`, `o_data_abt_ff out 1` each.

## Operation
- Update priority per clock: reset > clear > stall > load.
  - **Reset:** all outputs are 0, except the index outputs, which take `PHY_RAZ_REGISTER`.
  - **Clear** (`i_clear_from_writeback`=1):
    - `o_valid`, `o_mem_load_ff` and all exception outputs go to 0.
    - Index outputs go to `PHY_RAZ_REGISTER`.
    - Data and PC outputs are don't-care; the implementation holds them.
  - **Stall** (`i_data_stall`=1, no clear): every register holds.
  - **Load:** every register captures its ALU-side input, gated as below.
- When `i_valid_alu`=0 on a load cycle, behaviour is the same as clear.
- Data abort: `o_data_abt_ff` = `i_valid_alu & i_mem_op_alu & i_mem_fault`. When this is set, `o_mem_load_ff` is forced to 0 so no load-data write occurs; `o_valid` stays 1.
- Exception inputs are passed through only when `i_valid_alu`=1. There is no prioritisation here; writeback arbitrates.
- Load alignment uses `a = i_alu_result[1:0]`. Size flags are decoded with priority sbyte > ubyte > shalf > uhalf > word.
  - **Word:** `i_mem_rd_data` rotated right by `8*a` (ARMv4 unaligned LDR).
  - **ubyte:** byte `a` (bits `8a+7:8a`), zero-extended to 32.
  - **sbyte:** byte `a`, sign-extended from its bit 7.
  - **uhalf:** `a[1]`=0 selects `[15:0]`, `a[1]`=1 selects `[31:16]`; zero-extended. `a[0]` is ignored.
  - **shalf:** same half-word selection as uhalf, sign-extended from bit 15.
- `o_mem_rd_data` is computed when `i_mem_load_alu`=1; otherwise it captures 0.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- `i_mem_rd_data` and `i_mem_fault` are sampled on the same edge as the ALU-side inputs of the access. They are ignored while `i_data_stall`=1.
- While stalled, outputs are bit-stable for the full duration of the stall.
- Clear during a stall still takes effect on that edge.
- A valid instruction arriving in the cycle of a clear is dropped.
- Reset asserted mid-stall returns the stage to reset values on the next edge. The stage accepts inputs on the first edge after reset deasserts.
- There are no combinational paths from inputs to outputs.

## Test plan
- **Word rotate:** LDR with `i_alu_result`=0x1002, `i_mem_rd_data`=0xAABBCCDD, no stall -> next cycle `o_mem_rd_data`=0xCCDDAABB, `o_mem_load_ff`=1, `o_valid`=1.
- **Byte and halfword extension:** sbyte at a=3, data 0x80123456 -> 0xFFFFFF80. ubyte, same data -> 0x00000080. shalf at a=2, data 0x9000_1234 -> 0xFFFF9000. uhalf at a=0 -> 0x00001234.
- **Stall hold:** load result A, assert `i_data_stall` for 3 cycles while changing all inputs -> outputs stay equal to A; the new inputs are captured on the first unstalled edge.
- **Flush priority:** `i_clear_from_writeback`=1 together with `i_data_stall`=1 and a valid LDR carrying `i_irq_alu`=1 -> next cycle `o_valid`=0, `o_irq_ff`=0, `o_mem_load_ff`=0, indices=`PHY_RAZ_REGISTER`.
- **Data abort:** valid LDR with `i_mem_fault`=1 -> `o_data_abt_ff`=1, `o_mem_load_ff`=0, `o_valid`=1. A non-memory op with `i_mem_fault`=1 -> `o_data_abt_ff`=0.
- **Reset mid-stall:** assert `i_reset` during `i_data_stall`=1 -> all outputs at reset values next cycle. After deassertion, a valid ADD result 0x5 propagates with 1-cycle latency.

Source files
------------

// File: rtl/zap_memory_stage.sv
// zap_memory_stage
//
// Pipeline register between the ALU stage and writeback. It captures the ALU
// result, destination indices, flags and exception indicators, and aligns and
// sign/zero-extends the load word returned by the data cache. Everything
// appears on the outputs one cycle after it is sampled.
//
// Ports:
//   i_clk, i_reset              core clock, synchronous active-high reset
//   i_clear_from_writeback      flush: invalidates the stage
//   i_data_stall                data cache busy: every register holds
//   i_*_alu                     ALU-stage payload (result/address, flags,
//                               indices, load/mem-op, access size, PC+8,
//                               exception indicators)
//   i_mem_rd_data, i_mem_fault  raw load word and data abort from the cache
//   o_*                         registered payload presented to writeback
//
// Update priority per edge: reset > clear > stall > load. An invalid ALU
// slot on a load edge behaves exactly like a clear.

module zap_memory_stage #(
    parameter int FLAG_WDT         = 32,
    parameter int PHY_REGS         = 46,
    parameter int PHY_RAZ_REGISTER = 16,
    localparam int IW              = $clog2(PHY_REGS)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_clear_from_writeback,
    input  logic                i_data_stall,

    input  logic                i_valid_alu,
    input  logic [31:0]         i_alu_result,
    input  logic [FLAG_WDT-1:0] i_flags_alu,
    input  logic [IW-1:0]       i_destination_index_alu,
    input  logic [IW-1:0]       i_mem_srcdest_index_alu,
    input  logic                i_mem_load_alu,
    input  logic                i_mem_op_alu,
    input  logic                i_sbyte_alu,
    input  logic                i_ubyte_alu,
    input  logic                i_shalf_alu,
    input  logic                i_uhalf_alu,
    input  logic [31:0]         i_pc_plus_8_alu,
    input  logic                i_irq_alu,
    input  logic                i_fiq_alu,
    input  logic                i_instr_abt_alu,
    input  logic                i_swi_alu,
    input  logic                i_und_alu,

    input  logic [31:0]         i_mem_rd_data,
    input  logic                i_mem_fault,

    output logic                o_valid,
    output logic [31:0]         o_alu_result_ff,
    output logic [FLAG_WDT-1:0] o_flags_ff,
    output logic [IW-1:0]       o_destination_index_ff,
    output logic [IW-1:0]       o_mem_srcdest_index_ff,
    output logic                o_mem_load_ff,
    output logic [31:0]         o_mem_rd_data,
    output logic [31:0]         o_pc_plus_8_ff,
    output logic                o_irq_ff,
    output logic                o_fiq_ff,
    output logic                o_instr_abt_ff,
    output logic                o_swi_ff,
    output logic                o_und_ff,
    output logic                o_data_abt_ff
);

    localparam logic [IW-1:0] RAZ_IDX = IW'(PHY_RAZ_REGISTER);

    logic [1:0]  addr_lo;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] rot_word;
    logic [31:0] aligned_data;
    logic        data_abt;

    assign addr_lo  = i_alu_result[1:0];
    assign data_abt = i_valid_alu & i_mem_op_alu & i_mem_fault;

    always_comb begin
        sel_byte = i_mem_rd_data[{addr_lo, 3'b000} +: 8];
        // Half-word select ignores address bit 0.
        sel_half = addr_lo[1] ? i_mem_rd_data[31:16] : i_mem_rd_data[15:0];

        // Unaligned word loads rotate the word right by the byte offset.
        case (addr_lo)
            2'd0:    rot_word = i_mem_rd_data;
            2'd1:    rot_word = {i_mem_rd_data[7:0],  i_mem_rd_data[31:8]};
            2'd2:    rot_word = {i_mem_rd_data[15:0], i_mem_rd_data[31:16]};
            default: rot_word = {i_mem_rd_data[23:0], i_mem_rd_data[31:24]};
        endcase

        if (i_sbyte_alu)
            aligned_data = {{24{sel_byte[7]}}, sel_byte};
        else if (i_ubyte_alu)
            aligned_data = {24'd0, sel_byte};
        else if (i_shalf_alu)
            aligned_data = {{16{sel_half[15]}}, sel_half};
        else if (i_uhalf_alu)
            aligned_data = {16'd0, sel_half};
        else
            aligned_data = rot_word;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid                <= 1'b0;
            o_alu_result_ff        <= '0;
            o_flags_ff             <= '0;
            o_destination_index_ff <= RAZ_IDX;
            o_mem_srcdest_index_ff <= RAZ_IDX;
            o_mem_load_ff          <= 1'b0;
            o_mem_rd_data          <= '0;
            o_pc_plus_8_ff         <= '0;
            o_irq_ff               <= 1'b0;
            o_fiq_ff               <= 1'b0;
            o_instr_abt_ff         <= 1'b0;
            o_swi_ff               <= 1'b0;
            o_und_ff               <= 1'b0;
            o_data_abt_ff          <= 1'b0;
        end else if (i_clear_from_writeback || (!i_data_stall && !i_valid_alu)) begin
            // Data, flags and PC hold; only control and indices are scrubbed.
            o_valid                <= 1'b0;
            o_destination_index_ff <= RAZ_IDX;
            o_mem_srcdest_index_ff <= RAZ_IDX;
            o_mem_load_ff          <= 1'b0;
            o_irq_ff               <= 1'b0;
            o_fiq_ff               <= 1'b0;
            o_instr_abt_ff         <= 1'b0;
            o_swi_ff               <= 1'b0;
            o_und_ff               <= 1'b0;
            o_data_abt_ff          <= 1'b0;
        end else if (!i_data_stall) begin
            o_valid                <= 1'b1;
            o_alu_result_ff        <= i_alu_result;
            o_flags_ff             <= i_flags_alu;
            o_destination_index_ff <= i_destination_index_alu;
            o_mem_srcdest_index_ff <= i_mem_srcdest_index_alu;
            // An aborted access must not write load data back.
            o_mem_load_ff          <= i_mem_load_alu & ~data_abt;
            o_mem_rd_data          <= i_mem_load_alu ? aligned_data : 32'd0;
            o_pc_plus_8_ff         <= i_pc_plus_8_alu;
            o_irq_ff               <= i_irq_alu;
            o_fiq_ff               <= i_fiq_alu;
            o_instr_abt_ff         <= i_instr_abt_alu;
            o_swi_ff               <= i_swi_alu;
            o_und_ff               <= i_und_alu;
            o_data_abt_ff          <= data_abt;
        end
    end

endmodule

// File: tb/tb_zap_memory_stage.sv
module tb_zap_memory_stage;

    localparam int FLAG_WDT = 32;
    localparam int PHY_REGS = 46;
    localparam int RAZ      = 16;
    localparam int IW       = $clog2(PHY_REGS);

    logic                i_clk = 1'b0;
    logic                i_reset, i_clear_from_writeback, i_data_stall;
    logic                i_valid_alu;
    logic [31:0]         i_alu_result;
    logic [FLAG_WDT-1:0] i_flags_alu;
    logic [IW-1:0]       i_destination_index_alu, i_mem_srcdest_index_alu;
    logic                i_mem_load_alu, i_mem_op_alu;
    logic                i_sbyte_alu, i_ubyte_alu, i_shalf_alu, i_uhalf_alu;
    logic [31:0]         i_pc_plus_8_alu;
    logic                i_irq_alu, i_fiq_alu, i_instr_abt_alu, i_swi_alu, i_und_alu;
    logic [31:0]         i_mem_rd_data;
    logic                i_mem_fault;

    logic                o_valid;
    logic [31:0]         o_alu_result_ff;
    logic [FLAG_WDT-1:0] o_flags_ff;
    logic [IW-1:0]       o_destination_index_ff, o_mem_srcdest_index_ff;
    logic                o_mem_load_ff;
    logic [31:0]         o_mem_rd_data, o_pc_plus_8_ff;
    logic                o_irq_ff, o_fiq_ff, o_instr_abt_ff, o_swi_ff, o_und_ff, o_data_abt_ff;

    zap_memory_stage #(.FLAG_WDT(FLAG_WDT), .PHY_REGS(PHY_REGS), .PHY_RAZ_REGISTER(RAZ)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_clear_from_writeback(i_clear_from_writeback), .i_data_stall(i_data_stall),
        .i_valid_alu(i_valid_alu), .i_alu_result(i_alu_result), .i_flags_alu(i_flags_alu),
        .i_destination_index_alu(i_destination_index_alu),
        .i_mem_srcdest_index_alu(i_mem_srcdest_index_alu),
        .i_mem_load_alu(i_mem_load_alu), .i_mem_op_alu(i_mem_op_alu),
        .i_sbyte_alu(i_sbyte_alu), .i_ubyte_alu(i_ubyte_alu),
        .i_shalf_alu(i_shalf_alu), .i_uhalf_alu(i_uhalf_alu),
        .i_pc_plus_8_alu(i_pc_plus_8_alu),
        .i_irq_alu(i_irq_alu), .i_fiq_alu(i_fiq_alu), .i_instr_abt_alu(i_instr_abt_alu),
        .i_swi_alu(i_swi_alu), .i_und_alu(i_und_alu),
        .i_mem_rd_data(i_mem_rd_data), .i_mem_fault(i_mem_fault),
        .o_valid(o_valid), .o_alu_result_ff(o_alu_result_ff), .o_flags_ff(o_flags_ff),
        .o_destination_index_ff(o_destination_index_ff),
        .o_mem_srcdest_index_ff(o_mem_srcdest_index_ff),
        .o_mem_load_ff(o_mem_load_ff), .o_mem_rd_data(o_mem_rd_data),
        .o_pc_plus_8_ff(o_pc_plus_8_ff),
        .o_irq_ff(o_irq_ff), .o_fiq_ff(o_fiq_ff), .o_instr_abt_ff(o_instr_abt_ff),
        .o_swi_ff(o_swi_ff), .o_und_ff(o_und_ff), .o_data_abt_ff(o_data_abt_ff)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Expected output state of the stage.
    typedef struct {
        logic        valid;
        logic [31:0] result;
        logic [31:0] flags;
        int          dst;
        int          srcdest;
        logic        load;
        logic [31:0] rd;
        logic [31:0] pc;
        logic [4:0]  exc;     // irq, fiq, instr_abt, swi, und
        logic        dabt;
    } model_t;

    model_t m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Load extraction from first principles: byte lanes, little endian.
    function automatic logic [31:0] ref_align(input logic [31:0] data, input int a,
                                               input logic sb, input logic ub,
                                               input logic sh, input logic uh);
        logic [7:0]  b [4];
        logic [31:0] r;
        int          hb;
        for (int i = 0; i < 4; i++) b[i] = data[8*i +: 8];
        hb = (a >= 2) ? 2 : 0;
        if (sb)
            r = 32'($signed(b[a]));
        else if (ub)
            r = {24'd0, b[a]};
        else if (sh)
            r = 32'($signed({b[hb+1], b[hb]}));
        else if (uh)
            r = {16'd0, b[hb+1], b[hb]};
        else begin
            r = '0;
            for (int i = 0; i < 4; i++) r[8*i +: 8] = b[(i + a) % 4];
        end
        return r;
    endfunction

    function automatic model_t next_model(input model_t cur);
        model_t n;
        n = cur;
        if (i_reset) begin
            n = '{valid:0, result:0, flags:0, dst:RAZ, srcdest:RAZ, load:0,
                  rd:0, pc:0, exc:0, dabt:0};
        end else if (i_clear_from_writeback || (!i_data_stall && !i_valid_alu)) begin
            n.valid = 0; n.dst = RAZ; n.srcdest = RAZ; n.load = 0; n.exc = 0; n.dabt = 0;
        end else if (!i_data_stall) begin
            n.valid   = 1;
            n.result  = i_alu_result;
            n.flags   = i_flags_alu;
            n.dst     = int'(i_destination_index_alu);
            n.srcdest = int'(i_mem_srcdest_index_alu);
            n.dabt    = i_mem_op_alu && i_mem_fault;
            n.load    = i_mem_load_alu && !n.dabt;
            n.rd      = i_mem_load_alu ?
                        ref_align(i_mem_rd_data, int'(i_alu_result % 4), i_sbyte_alu,
                                  i_ubyte_alu, i_shalf_alu, i_uhalf_alu) : 32'd0;
            n.pc      = i_pc_plus_8_alu;
            n.exc     = {i_irq_alu, i_fiq_alu, i_instr_abt_alu, i_swi_alu, i_und_alu};
        end
        return n;
    endfunction

    task automatic check_all();
        check("valid",     {31'd0, o_valid}, {31'd0, m.valid});
        check("result",    o_alu_result_ff, m.result);
        check("flags",     o_flags_ff, m.flags);
        check("dst_idx",   32'(o_destination_index_ff), 32'(m.dst));
        check("srcdst_idx",32'(o_mem_srcdest_index_ff), 32'(m.srcdest));
        check("mem_load",  {31'd0, o_mem_load_ff}, {31'd0, m.load});
        check("rd_data",   o_mem_rd_data, m.rd);
        check("pc8",       o_pc_plus_8_ff, m.pc);
        check("exc",       {27'd0, o_irq_ff, o_fiq_ff, o_instr_abt_ff, o_swi_ff, o_und_ff},
                           {27'd0, m.exc});
        check("data_abt",  {31'd0, o_data_abt_ff}, {31'd0, m.dabt});
    endtask

    task automatic tick();
        model_t n;
        n = next_model(m);
        @(posedge i_clk);
        #1;
        m = n;
        check_all();
    endtask

    task automatic randomize_inputs();
        i_valid_alu             = ($urandom_range(9) < 8);
        i_alu_result            = $urandom;
        i_flags_alu             = $urandom;
        i_destination_index_alu = IW'($urandom_range(PHY_REGS - 1));
        i_mem_srcdest_index_alu = IW'($urandom_range(PHY_REGS - 1));
        i_mem_load_alu          = $urandom_range(1);
        i_mem_op_alu            = i_mem_load_alu | 1'($urandom_range(1));
        i_sbyte_alu             = ($urandom_range(3) == 0);
        i_ubyte_alu             = ($urandom_range(3) == 0);
        i_shalf_alu             = ($urandom_range(3) == 0);
        i_uhalf_alu             = ($urandom_range(3) == 0);
        i_pc_plus_8_alu         = $urandom;
        {i_irq_alu, i_fiq_alu, i_instr_abt_alu, i_swi_alu, i_und_alu} = 5'($urandom);
        i_mem_rd_data           = $urandom;
        i_mem_fault             = ($urandom_range(7) == 0);
    endtask

    task automatic set_plain();
        i_reset = 0; i_clear_from_writeback = 0; i_data_stall = 0;
        i_valid_alu = 1; i_flags_alu = 32'h6000_0010;
        i_destination_index_alu = 6'd3; i_mem_srcdest_index_alu = 6'd7;
        i_pc_plus_8_alu = 32'h0000_0108;
        {i_irq_alu, i_fiq_alu, i_instr_abt_alu, i_swi_alu, i_und_alu} = 5'd0;
        {i_sbyte_alu, i_ubyte_alu, i_shalf_alu, i_uhalf_alu} = 4'd0;
        i_mem_fault = 0; i_mem_op_alu = 0; i_mem_load_alu = 0;
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        sb, ub, sh, uh, fault, memop, load;
        logic [31:0] exp_rd;
        logic        exp_load, exp_abt;
    } vec_t;

    vec_t vecs [12];
    model_t snap;

    initial begin
        vecs[0]  = '{32'h0000_1002, 32'hAABB_CCDD, 0,0,0,0, 0, 1,1, 32'hCCDD_AABB, 1, 0};
        vecs[1]  = '{32'h0000_0003, 32'h8012_3456, 1,0,0,0, 0, 1,1, 32'hFFFF_FF80, 1, 0};
        vecs[2]  = '{32'h0000_0003, 32'h8012_3456, 0,1,0,0, 0, 1,1, 32'h0000_0080, 1, 0};
        vecs[3]  = '{32'h0000_0002, 32'h9000_1234, 0,0,1,0, 0, 1,1, 32'hFFFF_9000, 1, 0};
        vecs[4]  = '{32'h0000_0000, 32'h9000_1234, 0,0,0,1, 0, 1,1, 32'h0000_1234, 1, 0};
        vecs[5]  = '{32'h0000_0000, 32'h1122_3344, 0,0,0,0, 1, 1,1, 32'h1122_3344, 0, 1};
        vecs[6]  = '{32'h0000_0000, 32'h1122_3344, 0,0,0,0, 1, 0,0, 32'h0000_0000, 0, 0};
        vecs[7]  = '{32'h0000_0001, 32'h1122_3344, 0,0,0,0, 0, 1,1, 32'h4411_2233, 1, 0};
        vecs[8]  = '{32'h0000_0001, 32'h1122_3344, 0,1,0,0, 0, 1,1, 32'h0000_0033, 1, 0};
        vecs[9]  = '{32'h0000_0003, 32'h8001_7FFF, 0,0,1,0, 0, 1,1, 32'hFFFF_8001, 1, 0};
        vecs[10] = '{32'h0000_0020, 32'h1234_5678, 0,0,0,0, 0, 1,0, 32'h0000_0000, 0, 0};
        vecs[11] = '{32'h0000_0000, 32'h0000_807F, 1,0,0,1, 0, 1,1, 32'h0000_007F, 1, 0};

        set_plain();
        i_alu_result = 0; i_mem_rd_data = 0;
        i_reset = 1;
        m = '{valid:1, result:'1, flags:'1, dst:0, srcdest:0, load:1, rd:'1, pc:'1, exc:'1, dabt:1};
        tick();
        tick();
        i_reset = 0;

        // Directed single-cycle vectors.
        for (int i = 0; i < 12; i++) begin
            set_plain();
            i_alu_result  = vecs[i].addr;
            i_mem_rd_data = vecs[i].data;
            {i_sbyte_alu, i_ubyte_alu, i_shalf_alu, i_uhalf_alu} =
                {vecs[i].sb, vecs[i].ub, vecs[i].sh, vecs[i].uh};
            i_mem_fault    = vecs[i].fault;
            i_mem_op_alu   = vecs[i].memop;
            i_mem_load_alu = vecs[i].load;
            tick();
            check($sformatf("vec%0d_rd", i), o_mem_rd_data, vecs[i].exp_rd);
            check($sformatf("vec%0d_load", i), {31'd0, o_mem_load_ff}, {31'd0, vecs[i].exp_load});
            check($sformatf("vec%0d_abt", i), {31'd0, o_data_abt_ff}, {31'd0, vecs[i].exp_abt});
            check($sformatf("vec%0d_valid", i), {31'd0, o_valid}, 32'd1);
        end

        // Stall hold: outputs frozen for 3 stalled cycles while inputs churn.
        set_plain();
        i_mem_op_alu = 1; i_mem_load_alu = 1;
        i_alu_result = 32'h0000_1002; i_mem_rd_data = 32'hAABB_CCDD;
        tick();
        snap = m;
        for (int c = 0; c < 3; c++) begin
            randomize_inputs();
            i_valid_alu = 1;
            i_data_stall = 1;
            tick();
            check("stall_rd_hold", o_mem_rd_data, snap.rd);
            check("stall_result_hold", o_alu_result_ff, snap.result);
        end
        i_data_stall = 0;
        tick();
        check("unstall_capture", o_alu_result_ff, i_alu_result);

        // Clear wins over stall and drops a valid LDR carrying an IRQ.
        set_plain();
        i_mem_op_alu = 1; i_mem_load_alu = 1; i_irq_alu = 1;
        i_clear_from_writeback = 1; i_data_stall = 1;
        tick();
        check("flush_valid", {31'd0, o_valid}, 32'd0);
        check("flush_irq", {31'd0, o_irq_ff}, 32'd0);
        check("flush_load", {31'd0, o_mem_load_ff}, 32'd0);
        check("flush_dst", 32'(o_destination_index_ff), RAZ);
        check("flush_srcdst", 32'(o_mem_srcdest_index_ff), RAZ);

        // Reset mid-stall, then an ADD result of 5 with one-cycle latency.
        set_plain();
        i_alu_result = 32'h1234; i_mem_op_alu = 1; i_mem_load_alu = 1;
        tick();
        i_data_stall = 1;
        tick();
        i_reset = 1;
        tick();
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_result", o_alu_result_ff, 32'd0);
        check("rst_dst", 32'(o_destination_index_ff), RAZ);
        set_plain();
        i_alu_result = 32'd5;
        tick();
        check("add_result", o_alu_result_ff, 32'd5);
        check("add_valid", {31'd0, o_valid}, 32'd1);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            randomize_inputs();
            i_data_stall           = ($urandom_range(3) == 0);
            i_clear_from_writeback = ($urandom_range(9) == 0);
            i_reset                = ($urandom_range(49) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
